// File: rtl/writeback_buffer_pkg.sv
// Shared widths and the queued-entry layout for the writeback buffer.
package writeback_buffer_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/writeback_buffer_if.sv
// Result-producer handshake and register-file write port of the writeback buffer.
// valid/ready: a result transfers on any rising edge where resultValid and
// resultReady are both high; the producer holds reg/data stable while valid.
interface writeback_buffer_if;
  import writeback_buffer_pkg::*;

  logic              resultValid;
  logic [REG_W-1:0]  resultReg;
  logic [DATA_W-1:0] resultData;
  logic              resultReady;
  logic              writeEnable;
  logic [REG_W-1:0]  writeReg;
  logic [DATA_W-1:0] writeData;

  modport master (
    output resultValid, resultReg, resultData,
    input  resultReady, writeEnable, writeReg, writeData
  );

  modport slave (
    input  resultValid, resultReg, resultData,
    output resultReady, writeEnable, writeReg, writeData
  );
endinterface

// File: rtl/writeback_buffer_match.sv
// Youngest-match search over the queue entries for one bypass lookup port.
module writeback_match
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic   [DEPTH-1:0] valid,
  input  logic   [PTR_W-1:0] tail,
  input  logic   [REG_W-1:0] lookup,
  output logic               hit,
  output logic  [DATA_W-1:0] data
);
  // Walk from the oldest possible slot (tail) to the youngest (tail-1);
  // later matches overwrite earlier ones so the youngest wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid[tail + PTR_W'(k)] && (lookup != REG_ZERO) &&
          (entries[tail + PTR_W'(k)].idx == lookup)) begin
        hit  = 1'b1;
        data = entries[tail + PTR_W'(k)].data;
      end
    end
  end
endmodule

// File: rtl/writeback_buffer.sv
// In-order result queue feeding the register-file write port, with two
// combinational bypass lookups over the entries not yet committed.
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  writeback_buffer_if.slave   bus,
  input  logic [REG_W-1:0]    lookupReg1,
  input  logic [REG_W-1:0]    lookupReg2,
  output logic                bypassHit1,
  output logic [DATA_W-1:0]   bypassData1,
  output logic                bypassHit2,
  output logic [DATA_W-1:0]   bypassData2,
  output logic [REG_W-1:0]    occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic   [DEPTH-1:0] valid_q, valid_d;
  logic   [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic   [REG_W-1:0] occ_q, occ_d;
  logic               full, empty, enq, drain;

  always_comb begin
    full    = (occ_q == REG_W'(DEPTH));
    empty   = (occ_q == '0);
    drain   = !empty;
    // x0 results complete the handshake but are dropped here.
    enq     = bus.resultValid && !full && (bus.resultReg != REG_ZERO);
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      mem_d[tail_q]   = '{idx: bus.resultReg, data: bus.resultData};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({enq, drain})
      2'b10:   occ_d = occ_q + REG_W'(1);
      2'b01:   occ_d = occ_q - REG_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q   <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
    end
  end

  assign bus.resultReady = !full;
  assign bus.writeEnable = drain;
  assign bus.writeReg    = drain ? mem_q[head_q].idx  : '0;
  assign bus.writeData   = drain ? mem_q[head_q].data : '0;
  assign occupancy       = occ_q;

  writeback_match #(.DEPTH(DEPTH)) u_match1 (
    .entries (mem_q),
    .valid   (valid_q),
    .tail    (tail_q),
    .lookup  (lookupReg1),
    .hit     (bypassHit1),
    .data    (bypassData1)
  );

  writeback_match #(.DEPTH(DEPTH)) u_match2 (
    .entries (mem_q),
    .valid   (valid_q),
    .tail    (tail_q),
    .lookup  (lookupReg2),
    .hit     (bypassHit2),
    .data    (bypassData2)
  );
endmodule

// File: tb/tb_writeback_buffer.sv
// Bench for writeback_buffer: fixed vector table, reset corner cases and a
// randomized run against a queue-based model of the buffer.
module tb_writeback_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset_n;
  logic [4:0]  lookupReg1, lookupReg2;
  logic        bypassHit1, bypassHit2;
  logic [31:0] bypassData1, bypassData2;
  logic [4:0]  occupancy;

  int tests = 0;
  int fails = 0;

  writeback_buffer_if wif ();

  writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (wif),
    .lookupReg1  (lookupReg1),
    .lookupReg2  (lookupReg2),
    .bypassHit1  (bypassHit1),
    .bypassData1 (bypassData1),
    .bypassHit2  (bypassHit2),
    .bypassData2 (bypassData2),
    .occupancy   (occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state: {reg, data} entries in arrival order, plus register files
  logic [36:0] exp_q[$];
  logic [31:0] model_rf[32];
  logic [31:0] dut_rf[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] r, input logic [31:0] d,
                       input logic [4:0] l1, input logic [4:0] l2);
    wif.resultValid = v;
    wif.resultReg   = r;
    wif.resultData  = d;
    lookupReg1      = l1;
    lookupReg2      = l2;
  endtask

  task automatic model_bypass(input logic [4:0] lk, output bit hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
    if (lk != 0) begin
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i][36:32] == lk) begin
          hit  = 1'b1;
          data = exp_q[i][31:0];
          break;
        end
      end
    end
  endtask

  // One model-checked cycle: drive, check pre-edge outputs, then advance.
  task automatic step(input bit v, input logic [4:0] r, input logic [31:0] d,
                      input logic [4:0] l1, input logic [4:0] l2);
    bit          h;
    logic [31:0] bd;
    bit          was_full;
    bit          d_we;
    logic [4:0]  d_wr;
    logic [31:0] d_wd;
    @(negedge clk);
    drive(v, r, d, l1, l2);
    #1;
    was_full = (exp_q.size() == DEPTH);
    check("ready", wif.resultReady, !was_full);
    check("occupancy", occupancy, exp_q.size());
    check("we", wif.writeEnable, exp_q.size() != 0);
    check("wreg", wif.writeReg, exp_q.size() != 0 ? exp_q[0][36:32] : 5'd0);
    check("wdata", wif.writeData, exp_q.size() != 0 ? exp_q[0][31:0] : 32'd0);
    model_bypass(l1, h, bd);
    check("hit1", bypassHit1, h);
    check("bdata1", bypassData1, bd);
    model_bypass(l2, h, bd);
    check("hit2", bypassHit2, h);
    check("bdata2", bypassData2, bd);
    d_we = wif.writeEnable;
    d_wr = wif.writeReg;
    d_wd = wif.writeData;
    @(posedge clk);
    if (d_we) dut_rf[d_wr] = d_wd;
    if (exp_q.size() != 0) begin
      model_rf[exp_q[0][36:32]] = exp_q[0][31:0];
      void'(exp_q.pop_front());
    end
    if (v && !was_full && r != 0) exp_q.push_back({r, d});
  endtask

  typedef struct {
    bit v; logic [4:0] r; logic [31:0] d; logic [4:0] l1; logic [4:0] l2;
    bit we; logic [4:0] wr; logic [31:0] wd; logic [4:0] occ; bit rdy;
    bit h1; logic [31:0] bd1; bit h2; logic [31:0] bd2;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int bad;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12;
    check("rst_we", wif.writeEnable, 0);
    check("rst_occ", occupancy, 0);
    check("rst_wdata", wif.writeData, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_ready", wif.resultReady, 1);

    //         v  r  d             l1 l2  we wr wd            occ rdy h1 bd1           h2 bd2
    tbl[0] = '{1, 5, 32'hDEADBEEF, 5, 0,  0, 0, 0,            0,  1,  0, 0,            0, 0};
    tbl[1] = '{0, 0, 0,            5, 0,  1, 5, 32'hDEADBEEF, 1,  1,  1, 32'hDEADBEEF, 0, 0};
    tbl[2] = '{1, 0, 32'h12345678, 0, 0,  0, 0, 0,            0,  1,  0, 0,            0, 0};
    tbl[3] = '{0, 0, 0,            0, 0,  0, 0, 0,            0,  1,  0, 0,            0, 0};
    tbl[4] = '{1, 7, 32'h1,        0, 7,  0, 0, 0,            0,  1,  0, 0,            0, 0};
    tbl[5] = '{1, 7, 32'h2,        0, 7,  1, 7, 32'h1,        1,  1,  0, 0,            1, 32'h1};
    tbl[6] = '{0, 0, 0,            7, 7,  1, 7, 32'h2,        1,  1,  1, 32'h2,        1, 32'h2};
    tbl[7] = '{0, 0, 0,            7, 7,  0, 0, 0,            0,  1,  0, 0,            0, 0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].l1, tbl[i].l2);
      #1;
      check($sformatf("t%0d_we", i), wif.writeEnable, tbl[i].we);
      check($sformatf("t%0d_wreg", i), wif.writeReg, tbl[i].wr);
      check($sformatf("t%0d_wdata", i), wif.writeData, tbl[i].wd);
      check($sformatf("t%0d_occ", i), occupancy, tbl[i].occ);
      check($sformatf("t%0d_ready", i), wif.resultReady, tbl[i].rdy);
      check($sformatf("t%0d_hit1", i), bypassHit1, tbl[i].h1);
      check($sformatf("t%0d_bd1", i), bypassData1, tbl[i].bd1);
      check($sformatf("t%0d_hit2", i), bypassHit2, tbl[i].h2);
      check($sformatf("t%0d_bd2", i), bypassData2, tbl[i].bd2);
    end

    // back-to-back x1..x6, then let the queue empty
    for (int i = 1; i <= 6; i++) step(1, 5'(i), 32'h100 + 32'(i), 5'(i), 5'(i - 1));
    step(0, 0, 0, 6, 0);
    step(0, 0, 0, 0, 0);
    check("b2b_x6", dut_rf[6], 32'h106);

    // asynchronous reset while an entry is being drained
    step(1, 9, 32'hAAAA5555, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 9, 9);
    #1;
    check("pre_rst_we", wif.writeEnable, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_we", wif.writeEnable, 0);
    check("mid_rst_occ", occupancy, 0);
    check("mid_rst_hit1", bypassHit1, 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    step(0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 9);

    // randomized traffic with frequent x0 and register collisions
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 4)), $urandom,
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)));
    end
    for (int n = 0; n < DEPTH + 1; n++) step(0, 0, 0, 0, 0);

    bad = 0;
    for (int i = 0; i < 32; i++) if (dut_rf[i] !== model_rf[i]) bad++;
    check("rf_regs_mismatch", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
